// File: rtl/sprite_anim_mem.sv
// sprite_anim_mem
//   Multi-frame sprite store with an animation sequencer. NUM_FRAMES frames of
//   FRAME_PIXELS pixels share one dual-port RAM: port A is the CPU's Avalon-MM
//   slave, port B is a 2-stage pixel fetch for the renderer. The sequencer
//   starts on trigger and advances one frame every TICKS_PER_FRAME frame_ticks.
//
//   Optional feature macro: SPRITE_ANIM_LOOP_EN adds the loop input. With
//   loop=1 the animation wraps to frame 0 instead of ending with done.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   av_*                Avalon-MM slave, read latency 1, no waitrequest
//   trigger, frame_tick start/restart pulse, vsync pulse
//   loop                wrap mode (SPRITE_ANIM_LOOP_EN only)
//   pix_req/pix_offset  pixel fetch request, result 2 cycles later
//   pix_valid/pix_data  fetched pixel (0 when requested while idle)
//   active, frame_idx   sequencer status
//   done                1-cycle pulse at the end of a one-shot run
module sprite_anim_mem #(
    parameter int    DATA_W          = 8,
    parameter int    FRAME_PIXELS    = 1024,
    parameter int    NUM_FRAMES      = 3,
    parameter int    ADDR_W          = 12,
    parameter int    OFS_W           = 10,
    parameter int    TICKS_PER_FRAME = 4,
    parameter string INIT_FILE       = "",
    localparam int   FIDX_W          = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] av_address,
    input  logic              av_chipselect,
    input  logic              av_write,
    input  logic [DATA_W-1:0] av_writedata,
    input  logic              av_read,
    output logic [DATA_W-1:0] av_readdata,
    input  logic              trigger,
    input  logic              frame_tick,
`ifdef SPRITE_ANIM_LOOP_EN
    input  logic              loop,
`endif
    input  logic              pix_req,
    input  logic [OFS_W-1:0]  pix_offset,
    output logic              pix_valid,
    output logic [DATA_W-1:0] pix_data,
    output logic              active,
    output logic [FIDX_W-1:0] frame_idx,
    output logic              done
);

    localparam int DEPTH  = FRAME_PIXELS * NUM_FRAMES;
    localparam int TICK_W = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
    localparam int STAGES = 2;

    // Preload file is handed to the vendor RAM inference through the attribute.
    (* ram_init_file = INIT_FILE *) logic [DATA_W-1:0] r_mem [DEPTH];

    typedef enum logic {S_IDLE, S_PLAY} state_t;

    state_t            r_state;
    logic [FIDX_W-1:0] r_frame_idx;
    logic [TICK_W-1:0] r_tick_cnt;
    logic              r_active;
    logic              r_done;
    logic [DATA_W-1:0] r_av_rdata;
    logic [STAGES:1]   r_vld_pipe;
    logic [ADDR_W-1:0] r_s1_addr;
    logic              r_s1_act;
    logic [DATA_W-1:0] r_pix_data;

    logic              w_av_in_rng;
    logic              w_av_wr;
    logic              w_av_rd;
    logic              w_loop;
    logic [ADDR_W-1:0] w_pix_addr;

`ifdef SPRITE_ANIM_LOOP_EN
    assign w_loop = loop;
`else
    assign w_loop = 1'b0;
`endif

    assign w_av_in_rng = (32'(av_address) < DEPTH);
    assign w_av_wr     = av_chipselect & av_write & w_av_in_rng;
    assign w_av_rd     = av_chipselect & av_read;
    assign w_pix_addr  = ADDR_W'(r_frame_idx) * ADDR_W'(FRAME_PIXELS) + ADDR_W'(pix_offset);

    // Port A write. Reads elsewhere see the pre-write contents, which gives
    // old-data behaviour on both read ports during a same-address collision.
    always_ff @(posedge clk) begin
        if (w_av_wr)
            r_mem[av_address] <= av_writedata;
    end

    // Port A read, latency 1; out-of-range addresses read as 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_av_rdata <= '0;
        else if (w_av_rd)
            r_av_rdata <= w_av_in_rng ? r_mem[av_address] : '0;
    end

    // Pixel path: stage 1 captures address and active flag in the request
    // cycle, so a later frame change cannot alter a request already issued.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld_pipe <= '0;
            r_s1_addr  <= '0;
            r_s1_act   <= 1'b0;
            r_pix_data <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[STAGES-1:1], pix_req};
            if (pix_req) begin
                r_s1_addr <= w_pix_addr;
                r_s1_act  <= r_active;
            end
            if (r_vld_pipe[1])
                r_pix_data <= r_s1_act ? r_mem[r_s1_addr] : '0;
        end
    end

    // Sequencer. trigger has priority over frame_tick in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_frame_idx <= '0;
            r_tick_cnt  <= '0;
            r_active    <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (trigger) begin
                        r_state     <= S_PLAY;
                        r_active    <= 1'b1;
                        r_frame_idx <= '0;
                        r_tick_cnt  <= '0;
                    end
                end
                S_PLAY: begin
                    if (trigger) begin
                        r_frame_idx <= '0;
                        r_tick_cnt  <= '0;
                    end else if (frame_tick) begin
                        if (r_tick_cnt == TICK_W'(TICKS_PER_FRAME - 1)) begin
                            r_tick_cnt <= '0;
                            if (r_frame_idx == FIDX_W'(NUM_FRAMES - 1)) begin
                                r_frame_idx <= '0;
                                if (!w_loop) begin
                                    r_state  <= S_IDLE;
                                    r_active <= 1'b0;
                                    r_done   <= 1'b1;
                                end
                            end else begin
                                r_frame_idx <= r_frame_idx + 1'b1;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign av_readdata = r_av_rdata;
    assign pix_valid   = r_vld_pipe[STAGES];
    assign pix_data    = r_pix_data;
    assign active      = r_active;
    assign frame_idx   = r_frame_idx;
    assign done        = r_done;

endmodule

// File: tb/tb_sprite_anim_mem.sv
// Directed bench for sprite_anim_mem with default parameters.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
module tb_sprite_anim_mem;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [11:0] av_address;
    logic        av_chipselect, av_write, av_read;
    logic [7:0]  av_writedata;
    logic [7:0]  av_readdata;
    logic        trigger, frame_tick;
`ifdef SPRITE_ANIM_LOOP_EN
    logic        loop;
`endif
    logic        pix_req;
    logic [9:0]  pix_offset;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        active;
    logic [1:0]  frame_idx;
    logic        done;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int done_base;

    sprite_anim_mem dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .av_address   (av_address),
        .av_chipselect(av_chipselect),
        .av_write     (av_write),
        .av_writedata (av_writedata),
        .av_read      (av_read),
        .av_readdata  (av_readdata),
        .trigger      (trigger),
        .frame_tick   (frame_tick),
`ifdef SPRITE_ANIM_LOOP_EN
        .loop         (loop),
`endif
        .pix_req      (pix_req),
        .pix_offset   (pix_offset),
        .pix_valid    (pix_valid),
        .pix_data     (pix_data),
        .active       (active),
        .frame_idx    (frame_idx),
        .done         (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    task automatic av_wr(input logic [11:0] a, input logic [7:0] d);
        av_chipselect = 1'b1; av_write = 1'b1; av_address = a; av_writedata = d;
        tick1();
        av_chipselect = 1'b0; av_write = 1'b0;
    endtask

    task automatic av_rd(input string tag, input logic [11:0] a, input logic [7:0] exp);
        av_chipselect = 1'b1; av_read = 1'b1; av_address = a;
        tick1();
        av_chipselect = 1'b0; av_read = 1'b0;
        check(tag, 32'(av_readdata), 32'(exp));
    endtask

    task automatic ftick(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            tick1();
            frame_tick = 1'b0;
        end
    endtask

    task automatic pulse_trigger();
        trigger = 1'b1;
        tick1();
        trigger = 1'b0;
    endtask

    task automatic pix_fetch(input string tag, input logic [9:0] ofs, input logic [7:0] exp);
        pix_req = 1'b1; pix_offset = ofs;
        tick1();
        pix_req = 1'b0;
        tick1();
        check({tag, "_vld"}, 32'(pix_valid), 32'd1);
        check({tag, "_dat"}, 32'(pix_data), 32'(exp));
    endtask

    initial begin
        reset_n = 1'b0;
        av_address = '0; av_chipselect = 1'b0; av_write = 1'b0; av_read = 1'b0;
        av_writedata = '0; trigger = 1'b0; frame_tick = 1'b0;
        pix_req = 1'b0; pix_offset = '0;
`ifdef SPRITE_ANIM_LOOP_EN
        loop = 1'b0;
`endif
        repeat (3) tick1();
        check("rst_avrd", 32'(av_readdata), 32'd0);
        check("rst_pvld", 32'(pix_valid), 32'd0);
        check("rst_pdat", 32'(pix_data), 32'd0);
        check("rst_act", 32'(active), 32'd0);
        check("rst_fidx", 32'(frame_idx), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset_n = 1'b1;
        tick1();

        // Avalon load / readback, out-of-range read, same-cycle write+read.
        av_wr(12'd1030, 8'hA5);
        av_rd("av_rd1030", 12'd1030, 8'hA5);
        av_rd("av_rd3072", 12'd3072, 8'h00);
        av_wr(12'd3072, 8'hEE);
        av_rd("av_wr_oor", 12'd3072, 8'h00);
        av_chipselect = 1'b1; av_write = 1'b1; av_read = 1'b1;
        av_address = 12'd1030; av_writedata = 8'h5A;
        tick1();
        av_chipselect = 1'b0; av_write = 1'b0; av_read = 1'b0;
        check("av_coll_old", 32'(av_readdata), 32'h A5);
        av_rd("av_coll_new", 12'd1030, 8'h5A);

        // Preload offset 5 of frames 0/1/2.
        av_wr(12'd5, 8'h11);
        av_wr(12'd1029, 8'h22);
        av_wr(12'd2053, 8'h33);

        // One-shot run with pixel fetches along the way.
        check("idle_act", 32'(active), 32'd0);
        done_base = done_cnt;
        pulse_trigger();
        check("trig_act", 32'(active), 32'd1);
        check("trig_fidx", 32'(frame_idx), 32'd0);
        pix_fetch("pix_f0", 10'd5, 8'h11);
        tick1();
        check("pix_f0_idle", 32'(pix_valid), 32'd0);
        ftick(3);
        check("fidx_3tk", 32'(frame_idx), 32'd0);
        ftick(1);
        check("fidx_4tk", 32'(frame_idx), 32'd1);
        pix_fetch("pix_f1", 10'd5, 8'h22);
        // Back-to-back requests: offsets 5 and 6 of frame 1 (6 is addr 1030).
        pix_req = 1'b1; pix_offset = 10'd5;
        tick1();
        pix_offset = 10'd6;
        tick1();
        pix_req = 1'b0;
        check("burst0_vld", 32'(pix_valid), 32'd1);
        check("burst0_dat", 32'(pix_data), 32'h22);
        tick1();
        check("burst1_vld", 32'(pix_valid), 32'd1);
        check("burst1_dat", 32'(pix_data), 32'h5A);
        tick1();
        check("burst_end", 32'(pix_valid), 32'd0);
        ftick(4);
        check("fidx_8tk", 32'(frame_idx), 32'd2);
        pix_fetch("pix_f2", 10'd5, 8'h33);
        ftick(3);
        check("pre_done", 32'(done), 32'd0);
        ftick(1);
        check("done_pulse", 32'(done), 32'd1);
        check("done_act", 32'(active), 32'd0);
        check("done_fidx", 32'(frame_idx), 32'd0);
        tick1();
        check("done_clear", 32'(done), 32'd0);
        check("done_once", 32'(done_cnt - done_base), 32'd1);
        pix_fetch("pix_idle", 10'd5, 8'h00);

        // Trigger beats a same-cycle frame_tick and restarts the tick count.
        pulse_trigger();
        ftick(10);
        check("prio_f2", 32'(frame_idx), 32'd2);
        trigger = 1'b1; frame_tick = 1'b1;
        tick1();
        trigger = 1'b0; frame_tick = 1'b0;
        check("prio_fidx", 32'(frame_idx), 32'd0);
        check("prio_act", 32'(active), 32'd1);
        ftick(3);
        check("prio_tk3", 32'(frame_idx), 32'd0);
        ftick(1);
        check("prio_tk4", 32'(frame_idx), 32'd1);

        // Asynchronous reset with requests in flight.
        pix_req = 1'b1; pix_offset = 10'd5;
        tick1();
        tick1();
        check("inflt_vld", 32'(pix_valid), 32'd1);
        check("inflt_dat", 32'(pix_data), 32'h22);
        #2;
        reset_n = 1'b0;
        pix_req = 1'b0;
        #1;
        check("arst_avrd", 32'(av_readdata), 32'd0);
        check("arst_pvld", 32'(pix_valid), 32'd0);
        check("arst_pdat", 32'(pix_data), 32'd0);
        check("arst_act", 32'(active), 32'd0);
        check("arst_fidx", 32'(frame_idx), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick1();
        check("post_rst_v1", 32'(pix_valid), 32'd0);
        tick1();
        check("post_rst_v2", 32'(pix_valid), 32'd0);
        pix_fetch("post_rst_px", 10'd5, 8'h00);

`ifdef SPRITE_ANIM_LOOP_EN
        // Loop mode: frames wrap, done never pulses.
        loop = 1'b1;
        done_base = done_cnt;
        pulse_trigger();
        for (int f = 0; f < 6; f++) begin
            check("loop_fidx", 32'(frame_idx), 32'(f % 3));
            ftick(4);
        end
        check("loop_wrap", 32'(frame_idx), 32'd0);
        check("loop_act", 32'(active), 32'd1);
        check("loop_nodone", 32'(done_cnt - done_base), 32'd0);
        loop = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sprite_anim_mem.md
# sprite_anim_mem

Parametrised, multi-frame sprite store with a built-in animation sequencer, replacing fixed single-sprite ROMs such as the explosion store. It holds NUM_FRAMES frames of FRAME_PIXELS pixels each. The CPU loads and reads it over an Avalon-MM slave. A 2-stage pixel-fetch port serves the VGA renderer, and the sequencer steps frames on vsync ticks after a trigger.

## Interface
- DATA_W, 8: pixel/palette-index width.
- FRAME_PIXELS, 1024: pixels per frame (32x32).
- NUM_FRAMES, 3: frames stored; total depth = FRAME_PIXELS*NUM_FRAMES (default 3072).
- ADDR_W, 12: Avalon address width, >= clog2(total depth).
- OFS_W, 10: pixel offset width, = clog2(FRAME_PIXELS).
- TICKS_PER_FRAME, 4: frame_tick pulses per animation frame, >= 1.
- INIT_FILE, "": memory init file; empty means no initialisation.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- av_address  in  ADDR_W  Avalon word address.
- av_chipselect  in  1  Avalon select.
- av_write  in  1  write strobe.
- av_writedata  in  DATA_W  write data.
- av_read  in  1  read strobe.
- av_readdata  out  DATA_W  read data, fixed latency 1.
- trigger  in  1  single-cycle start/restart pulse.
- frame_tick  in  1  single-cycle vsync pulse.
- loop  in  1  loop mode; present only with SPRITE_ANIM_LOOP_EN.
- pix_req  in  1  pixel fetch request.
- pix_offset  in  OFS_W  pixel index within the current frame.
- pix_valid  out  1  pix_data is valid.
- pix_data  out  DATA_W  fetched pixel; 0 is transparent.
- active  out  1  animation is playing.
- frame_idx  out  clog2(NUM_FRAMES)  current frame.
- done  out  1  one-cycle pulse at the end of a one-shot run.

## Operation
- **Storage:** true dual-port RAM of total depth × DATA_W.
  - Port A belongs to Avalon; port B belongs to the pixel path.
- **Avalon write:** occurs when av_chipselect & av_write. Addresses at or beyond the total depth are ignored.
- **Avalon read:** occurs when av_chipselect & av_read. Out-of-range reads return 0.
- **Avalon write and read in the same cycle:** the write is performed; av_readdata returns the old data.
- **Sequencer FSM: IDLE → PLAY.**
  - IDLE: active=0, frame_idx=0.
  - trigger moves IDLE to PLAY with frame_idx=0 and tick_cnt=0.
  - In PLAY, each frame_tick increments tick_cnt. When tick_cnt reaches TICKS_PER_FRAME-1 and a tick arrives, tick_cnt clears and frame_idx advances.
  - When the last frame ends in one-shot mode, the FSM goes to IDLE, frame_idx returns to 0, and done pulses for 1 cycle.
  - When the last frame ends with loop=1, frame_idx wraps to 0 and the FSM stays in PLAY.
  - trigger in PLAY restarts at frame 0 with tick_cnt 0.
  - If trigger and frame_tick arrive in the same cycle, trigger wins and the tick is discarded.
- **Pixel path:** stage 1 registers addr = frame_idx*FRAME_PIXELS + pix_offset together with the active flag; stage 2 is the RAM read.
  - frame_idx is sampled in the request cycle, so a frame change mid-scanline affects only later requests.
  - pix_valid follows every pix_req. pix_data is 0 if the request was made while IDLE.
- **Write/read collision:** an Avalon write and a pixel read to the same address in the same cycle return the old data on the pixel port.
- **Reset:** asynchronous and immediate. All state clears and any pending pixel requests are dropped.

## Timing
- Reset values of all outputs:
  - av_readdata = 0, pix_valid = 0, pix_data = 0.
  - active = 0, frame_idx = 0, done = 0.
- Avalon read: av_readdata is valid on the edge following the read cycle. No waitrequest.
- Pixel fetch: request at cycle N gives pix_valid/pix_data at cycle N+2. The path is fully pipelined at 1 request per cycle.
- trigger at cycle N: active=1 and frame_idx=0 from cycle N+1.
- Frame advance: frame_idx updates on the cycle after the qualifying frame_tick.
- done is asserted on the cycle after the final tick, coincident with active falling.
- Reset deasserting mid-stream: the first valid request is the first pix_req sampled after reset_n rises.

## Configuration
- SPRITE_ANIM_LOOP_EN defined:
  - The loop port exists.
  - loop=1 wraps frames indefinitely and done never pulses.
  - loop is sampled on each last-frame advance.
- SPRITE_ANIM_LOOP_EN undefined:
  - No loop port.
  - Always one-shot: each trigger plays frames 0..NUM_FRAMES-1 once, then done.

## Test plan
- Avalon load/readback: write 0xA5 at addr 1030, read it back → av_readdata=0xA5 one cycle later. Read addr 3072 → 0.
- Pixel fetch: preload 0x11/0x22/0x33 at offset 5 of frames 0/1/2. trigger, then pix_req offset 5 → pix_data=0x11 at N+2. After 4 frame_ticks, the same request gives 0x22.
- One-shot end: trigger, then 12 frame_ticks → done pulses once, active=0, frame_idx=0. A subsequent pix_req returns 0.
- Trigger priority: mid-frame 2, assert trigger together with frame_tick → frame_idx=0 and tick_cnt=0 next cycle; the tick is ignored.
- Loop (macro on, loop=1): 24 ticks → frame_idx sequence 0,1,2,0,1,2. done is never asserted.
- Async reset: assert reset_n low during PLAY with pix_reqs in flight → all outputs are 0 immediately. No pix_valid after release until a new pix_req.
